// File: rtl/cam_pkg.sv
// Shared types and constants for the camera stream generator.
package cam_pkg;

    // Frame timing phases.
    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } cam_state_e;

    // Test pattern codes.
    localparam logic [1:0] PAT_GRAD  = 2'd0;
    localparam logic [1:0] PAT_CNT   = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_CHK   = 2'd3;

    // Clocks per line: active bytes followed by horizontal blanking.
    function automatic int line_t(input int h_active, input int bpp, input int h_blank);
        return h_active * bpp + h_blank;
    endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// Sensor-side video bus: frame sync, line valid and one byte per clock.
interface cam_stream_gen_if #(
    parameter int DATA_W = 8
);
    logic              vsync;
    logic              href;
    logic [DATA_W-1:0] dout;

    // Generator drives the bus.
    modport master (output vsync, output href, output dout);
    // Capture side observes it.
    modport slave  (input vsync, input href, input dout);
endinterface

// File: rtl/cam_pattern.sv
// Combinational pixel generation and byte selection for the test patterns.
module cam_pattern
    import cam_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BPP    = 2
) (
    input  logic [1:0]        pat_sel,
    input  logic [7:0]        row,
    input  logic [7:0]        col,
    input  logic              b,
    input  logic [7:0]        byte_cnt,
    input  logic [15:0]       solid,
    output logic [DATA_W-1:0] byte_out
);

    logic [15:0] pix;
    logic [7:0]  sel;

    // Build the 16-bit pixel, then pick the byte for this position in the pixel.
    always_comb begin
        pix = '0;
        case (pat_sel)
            PAT_GRAD:  pix = {row, col};
            PAT_SOLID: pix = solid;
            PAT_CHK:   pix = (row[3] ^ col[3]) ? 16'hFFFF : 16'h0000;
            default:   pix = '0;
        endcase
        // High byte goes first when two bytes make up a pixel.
        sel = (BPP == 2 && !b) ? pix[15:8] : pix[7:0];
        // The byte counter ignores pixel packing entirely.
        if (pat_sel == PAT_CNT) begin
            sel = byte_cnt;
        end
        byte_out = DATA_W'(sel);
    end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style frame timing generator with selectable test patterns.
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 120,
    parameter int BPP      = 2,
    parameter int H_BLANK  = 16,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 2,
    parameter int V_FRONT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  pat_sel,
    input  logic [15:0] solid,
    output logic        frame_done,
    output logic        busy,
    cam_stream_gen_if.master vid
);

    localparam int LINE_T = line_t(H_ACTIVE, BPP, H_BLANK);
    localparam int HW     = $clog2(LINE_T + 1);
    localparam int LW     = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT + 1);

    localparam logic [HW-1:0] LAST_H = HW'(LINE_T - 1);
    localparam logic [HW-1:0] ACT_B  = HW'(H_ACTIVE * BPP);

    cam_state_e        state_q, state_nxt;
    logic [HW-1:0]     hcnt_q, hcnt_nxt;
    logic [LW-1:0]     lcnt_q, lcnt_nxt;
    logic [7:0]        byte_cnt_q, byte_cnt_nxt;
    logic              start;

    logic [1:0]        pat_q;
    logic [15:0]       solid_q;

    logic              vsync_q, vsync_nxt;
    logic              href_q, href_nxt;
    logic [DATA_W-1:0] dout_q, dout_nxt;
    logic              fd_q, fd_nxt;
    logic              busy_q, busy_nxt;

    logic [7:0]        row_nxt, col_nxt;
    logic              b_nxt;
    logic [DATA_W-1:0] pat_byte;

    // Last line index of each vertical phase.
    function automatic logic [LW-1:0] last_line(input cam_state_e s);
        case (s)
            VSYNC:   return LW'(V_SYNC - 1);
            VBACK:   return LW'(V_BACK - 1);
            ACTIVE:  return LW'(V_ACTIVE - 1);
            VFRONT:  return LW'(V_FRONT - 1);
            default: return '0;
        endcase
    endfunction

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            byte_cnt_q <= '0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            dout_q     <= '0;
            fd_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            hcnt_q     <= hcnt_nxt;
            lcnt_q     <= lcnt_nxt;
            byte_cnt_q <= byte_cnt_nxt;
            vsync_q    <= vsync_nxt;
            href_q     <= href_nxt;
            dout_q     <= dout_nxt;
            fd_q       <= fd_nxt;
            busy_q     <= busy_nxt;
        end
    end

    // Pattern settings are captured once per frame, on the edge that enters VSYNC.
    always_ff @(posedge clock) begin
        if (start) begin
            pat_q   <= pat_sel;
            solid_q <= solid;
        end
    end

    // Next phase and position; every phase is a whole number of lines.
    always_comb begin
        state_nxt = state_q;
        hcnt_nxt  = hcnt_q;
        lcnt_nxt  = lcnt_q;
        start     = 1'b0;
        if (state_q == IDLE) begin
            if (en) begin
                state_nxt = VSYNC;
                hcnt_nxt  = '0;
                lcnt_nxt  = '0;
                start     = 1'b1;
            end
        end else if (hcnt_q != LAST_H) begin
            hcnt_nxt = hcnt_q + 1'b1;
        end else begin
            hcnt_nxt = '0;
            if (lcnt_q != last_line(state_q)) begin
                lcnt_nxt = lcnt_q + 1'b1;
            end else begin
                lcnt_nxt = '0;
                case (state_q)
                    VSYNC:  state_nxt = VBACK;
                    VBACK:  state_nxt = ACTIVE;
                    ACTIVE: state_nxt = VFRONT;
                    VFRONT: begin
                        // en is only looked at here, so frames never stop midway.
                        if (en) begin
                            state_nxt = VSYNC;
                            start     = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Pixel coordinates of the byte that will be on the bus next clock.
    assign row_nxt = 8'(lcnt_nxt);
    assign col_nxt = 8'(32'(hcnt_nxt) / BPP);
    assign b_nxt   = 1'(32'(hcnt_nxt) % BPP);

    cam_pattern #(
        .DATA_W (DATA_W),
        .BPP    (BPP)
    ) u_pattern (
        .pat_sel  (pat_q),
        .row      (row_nxt),
        .col      (col_nxt),
        .b        (b_nxt),
        .byte_cnt (byte_cnt_q),
        .solid    (solid_q),
        .byte_out (pat_byte)
    );

    // Output values for the next clock, derived from the next state so they can be registered.
    always_comb begin
        vsync_nxt    = (state_nxt == VSYNC);
        href_nxt     = (state_nxt == ACTIVE) && (hcnt_nxt < ACT_B);
        dout_nxt     = href_nxt ? pat_byte : '0;
        fd_nxt       = (state_nxt == VFRONT) && (hcnt_nxt == LAST_H) &&
                       (lcnt_nxt == LW'(V_FRONT - 1));
        busy_nxt     = (state_nxt != IDLE);
        byte_cnt_nxt = start ? 8'd0 : byte_cnt_q + 8'(href_nxt);
    end

    assign vid.vsync  = vsync_q;
    assign vid.href   = href_q;
    assign vid.dout   = dout_q;
    assign frame_done = fd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen using a reduced frame geometry (LINE_T=10, frame=60).
module tb_cam_stream_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en    = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [15:0] solid   = 16'h0000;
    logic        frame_done;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Per-clock samples of one capture window.
    logic       s_v  [0:63];
    logic       s_h  [0:63];
    logic [7:0] s_d  [0:63];
    logic       s_fd [0:63];
    logic       s_bz [0:63];

    cam_stream_gen_if #(.DATA_W(8)) vid ();

    cam_stream_gen #(
        .DATA_W   (8),
        .H_ACTIVE (4),
        .V_ACTIVE (3),
        .BPP      (2),
        .H_BLANK  (2),
        .V_SYNC   (1),
        .V_BACK   (1),
        .V_FRONT  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .pat_sel    (pat_sel),
        .solid      (solid),
        .frame_done (frame_done),
        .busy       (busy),
        .vid        (vid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample n clocks on falling edges; at sample chg_at apply new pattern/solid/en.
    task automatic capture(input int n, input int chg_at, input logic [1:0] np,
                           input logic [15:0] ns, input logic ne);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            s_v[i]  = vid.vsync;
            s_h[i]  = vid.href;
            s_d[i]  = vid.dout;
            s_fd[i] = frame_done;
            s_bz[i] = busy;
            if (i == chg_at) begin
                pat_sel = np;
                solid   = ns;
                en      = ne;
            end
        end
    endtask

    function automatic logic [63:0] line_bytes(input int first);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], s_d[first + i]};
        return r;
    endfunction

    function automatic int count_v(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(s_v[i]);
        return c;
    endfunction

    function automatic int count_h(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(s_h[i]);
        return c;
    endfunction

    function automatic int count_fd(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(s_fd[i]);
        return c;
    endfunction

    // Number of href bytes that break the 0,1,2,... sequence.
    function automatic int cnt_seq_errs();
        int e = 0;
        int k = 0;
        for (int i = 0; i < 60; i++) begin
            if (s_h[i]) begin
                if (s_d[i] != 8'(k)) e++;
                k++;
            end
        end
        return e;
    endfunction

    // Number of href bytes that break the A5,5A pairing.
    function automatic int solid_errs();
        int e = 0;
        int k = 0;
        for (int i = 0; i < 60; i++) begin
            if (s_h[i]) begin
                if (s_d[i] != ((k % 2 == 0) ? 8'hA5 : 8'h5A)) e++;
                k++;
            end
        end
        return e;
    endfunction

    // Bytes that are nonzero while href is low.
    function automatic int idle_data_errs();
        int e = 0;
        for (int i = 0; i < 60; i++) if (!s_h[i] && s_d[i] != 8'h00) e++;
        return e;
    endfunction

    initial begin
        int found;

        // Reset held with en high: everything stays quiet.
        en = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_vsync", 64'(vid.vsync), 64'd0);
        check("rst_href",  64'(vid.href),  64'd0);
        check("rst_dout",  64'(vid.dout),  64'd0);
        check("rst_fd",    64'(frame_done), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);

        // Frame 1: gradient; pat_sel changes right after the latch and must not matter.
        reset = 1'b1;
        capture(60, 0, 2'd1, 16'h0000, 1'b1);
        check("f1_vsync_first", 64'(s_v[0]),  64'd1);
        check("f1_busy_first",  64'(s_bz[0]), 64'd1);
        check("f1_vsync_cnt",   64'(count_v(0, 59)), 64'd10);
        check("f1_vsync_end",   64'(s_v[10]), 64'd0);
        check("f1_href_cnt",    64'(count_h(0, 59)), 64'd24);
        check("f1_line0",       line_bytes(20), 64'h0000_0001_0002_0003);
        check("f1_hblank",      64'({s_h[28], s_h[29]}), 64'd0);
        check("f1_line2",       line_bytes(40), 64'h0200_0201_0202_0203);
        check("f1_fd_last",     64'(s_fd[59]), 64'd1);
        check("f1_fd_early",    64'(count_fd(0, 58)), 64'd0);
        check("f1_idle_data",   64'(idle_data_errs()), 64'd0);

        // Frame 2: byte counter, back to back with frame 1.
        capture(60, -1, 2'd1, 16'h0000, 1'b1);
        check("f2_vsync_rerise", 64'(s_v[0]), 64'd1);
        check("f2_href_cnt",     64'(count_h(0, 59)), 64'd24);
        check("f2_cnt_seq",      64'(cnt_seq_errs()), 64'd0);
        check("f2_fd_last",      64'(s_fd[59]), 64'd1);
        check("f2_fd_early",     64'(count_fd(0, 58)), 64'd0);

        // Frame 3: counter again restarts at 0; solid request arrives mid-frame.
        capture(60, 10, 2'd2, 16'hA55A, 1'b1);
        check("f3_cnt_first",  64'(s_d[20]), 64'd0);
        check("f3_cnt_seq",    64'(cnt_seq_errs()), 64'd0);
        check("f3_fd_last",    64'(s_fd[59]), 64'd1);

        // Frame 4: solid A55A; en drops mid-ACTIVE, frame still completes.
        capture(62, 25, 2'd2, 16'hA55A, 1'b0);
        check("f4_vsync_first", 64'(s_v[0]), 64'd1);
        check("f4_solid",       64'(solid_errs()), 64'd0);
        check("f4_href_cnt",    64'(count_h(0, 59)), 64'd24);
        check("f4_fd_last",     64'(s_fd[59]), 64'd1);
        check("f4_busy_end",    64'(s_bz[59]), 64'd1);
        check("f4_idle_busy",   64'({s_bz[60], s_bz[61]}), 64'd0);
        check("f4_idle_vsync",  64'({s_v[60], s_v[61]}), 64'd0);

        // Restart, then assert reset in the middle of an active line.
        pat_sel = 2'd0;
        en      = 1'b1;
        found   = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clock);
            if (vid.href) found = 1;
        end
        check("wait_href", 64'(found), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_href",  64'(vid.href),  64'd0);
        check("async_vsync", 64'(vid.vsync), 64'd0);
        check("async_dout",  64'(vid.dout),  64'd0);
        check("async_busy",  64'(busy),      64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Fresh frame after reset begins from row 0, col 0.
        capture(60, -1, 2'd0, 16'h0000, 1'b1);
        check("f5_vsync_first", 64'(s_v[0]), 64'd1);
        check("f5_line0",       line_bytes(20), 64'h0000_0001_0002_0003);
        check("f5_line1",       line_bytes(30), 64'h0100_0101_0102_0103);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
